// File: rtl/mtr_drv_ctrl_if.sv
// Control-side bus of the motor drive sequencer: speed request in, PWM11 drive word out.
interface mtr_drv_ctrl_if;
   localparam int unsigned REQ_W  = 12;
   localparam int unsigned DUTY_W = 11;

   logic              en;
   logic [REQ_W-1:0]  spd_req;
   logic              req_vld;
   logic [DUTY_W-1:0] duty;
   logic              dir;
   logic              coast;
   logic              at_spd;
   logic              prd_tick;

   // Speed/balance loop side
   modport master (
      output en, spd_req, req_vld,
      input  duty, dir, coast, at_spd, prd_tick
   );

   // Sequencer side
   modport slave (
      input  en, spd_req, req_vld,
      output duty, dir, coast, at_spd, prd_tick
   );
endinterface

// File: rtl/mtr_drv_ctrl.sv
// Motor drive sequencer: slews the PWM11 duty word once per PWM period and
// inserts a coast dead-time around every direction reversal.
module mtr_drv_ctrl #(
   parameter int unsigned PERIOD       = 2048,
   parameter int unsigned RAMP_STEP    = 32,
   parameter int unsigned DEAD_PERIODS = 2
) (
   input logic           clk,
   input logic           rst_n,
   mtr_drv_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = 11;
   localparam int unsigned MAG_W = 11;
   localparam int unsigned ACC_W = 12;
   localparam int unsigned DC_W  = $clog2(DEAD_PERIODS + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
   localparam logic [ACC_W-1:0] STEP     = ACC_W'(RAMP_STEP);
   localparam logic [ACC_W-1:0] MAG_MAX  = ACC_W'(2047);
   localparam logic [DC_W-1:0]  DEAD_LD  = DC_W'(DEAD_PERIODS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             prd_tick_q, prd_tick_d;
   logic             tgt_dir_q, tgt_dir_d;
   logic [MAG_W-1:0] tgt_mag_q, tgt_mag_d;
   logic [DC_W-1:0]  dead_q, dead_d;
   logic [MAG_W-1:0] duty_q, duty_d;
   logic             dir_q, dir_d;
   logic             coast_q, coast_d;
   logic             at_spd_q, at_spd_d;

   logic [ACC_W-1:0] req_abs;
   logic [MAG_W-1:0] req_mag;
   logic [ACC_W-1:0] duty_ext, tgt_ext, diff, step, ramp_sum;
   logic [MAG_W-1:0] ramp_duty, dn_duty;

   // Period counter kept in lock-step with PWM11; tick marks the last clock of a period
   always_comb begin
      cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      prd_tick_d = (cnt_d == CNT_LAST);
   end

   // Target capture; the next-value is used by the ramp so a request on a tick takes effect at once
   always_comb begin
      req_abs   = bus.spd_req[ACC_W-1] ? (~bus.spd_req + ACC_W'(1)) : bus.spd_req;
      req_mag   = (req_abs > MAG_MAX) ? MAG_W'(MAG_MAX) : req_abs[MAG_W-1:0];
      tgt_dir_d = tgt_dir_q;
      tgt_mag_d = tgt_mag_q;
      if (bus.req_vld) begin
         tgt_dir_d = bus.spd_req[ACC_W-1];
         tgt_mag_d = req_mag;
      end
   end

   // Clamped one-step moves of the duty word, computed 12 bits wide so nothing wraps
   always_comb begin
      duty_ext = ACC_W'(duty_q);
      tgt_ext  = ACC_W'(tgt_mag_d);
      if (tgt_ext >= duty_ext) begin
         diff     = tgt_ext - duty_ext;
         step     = (diff < STEP) ? diff : STEP;
         ramp_sum = duty_ext + step;
      end else begin
         diff     = duty_ext - tgt_ext;
         step     = (diff < STEP) ? diff : STEP;
         ramp_sum = duty_ext - step;
      end
      ramp_duty = (ramp_sum > MAG_MAX) ? MAG_W'(MAG_MAX) : ramp_sum[MAG_W-1:0];
      dn_duty   = (duty_ext > STEP) ? MAG_W'(duty_ext - STEP) : '0;
   end

   // Sequencing: enable overrides immediately, everything else moves only on a period tick
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      dead_d  = dead_q;
      if (!bus.en) begin
         state_d = ST_IDLE;
         duty_d  = '0;
      end else if (prd_tick_q) begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_RUN;
               dir_d   = tgt_dir_d;
               duty_d  = '0;
            end
            ST_RUN: begin
               if (tgt_dir_d == dir_q) begin
                  duty_d = ramp_duty;
               end else if (duty_q != '0) begin
                  duty_d = dn_duty;
               end else begin
                  state_d = ST_DEAD;
                  dead_d  = DEAD_LD;
               end
            end
            ST_DEAD: begin
               if (dead_q <= DC_W'(1)) begin
                  state_d = ST_RUN;
                  dir_d   = tgt_dir_d;
               end else begin
                  dead_d = dead_q - DC_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               duty_d  = '0;
            end
         endcase
      end
      coast_d  = (state_d != ST_RUN);
      at_spd_d = (state_d == ST_RUN) && (duty_d == tgt_mag_d) && (dir_d == tgt_dir_d);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         prd_tick_q <= 1'b0;
         tgt_dir_q  <= 1'b0;
         tgt_mag_q  <= '0;
         dead_q     <= '0;
         duty_q     <= '0;
         dir_q      <= 1'b0;
         coast_q    <= 1'b1;
         at_spd_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prd_tick_q <= prd_tick_d;
         tgt_dir_q  <= tgt_dir_d;
         tgt_mag_q  <= tgt_mag_d;
         dead_q     <= dead_d;
         duty_q     <= duty_d;
         dir_q      <= dir_d;
         coast_q    <= coast_d;
         at_spd_q   <= at_spd_d;
      end
   end

   assign bus.duty     = duty_q;
   assign bus.dir      = dir_q;
   assign bus.coast    = coast_q;
   assign bus.at_spd   = at_spd_q;
   assign bus.prd_tick = prd_tick_q;
endmodule

// File: tb/tb_mtr_drv_ctrl.sv
// Bench for mtr_drv_ctrl: a short-period instance is checked against a
// per-clock behavioural model; a full-period instance checks tick timing.
module tb_mtr_drv_ctrl;
   localparam int PF = 32;
   localparam int PS = 2048;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DEAD = 2;
   localparam logic [14:0] RST_VEC = {11'd0, 1'b0, 1'b1, 1'b0, 1'b0};

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   mtr_drv_ctrl_if bf();
   mtr_drv_ctrl_if bs();

   assign bs.en      = bf.en;
   assign bs.req_vld = bf.req_vld;
   assign bs.spd_req = bf.spd_req;

   mtr_drv_ctrl #(.PERIOD(PF)) u_fast (.clk(clk), .rst_n(rst_n), .bus(bf));
   mtr_drv_ctrl                u_slow (.clk(clk), .rst_n(rst_n), .bus(bs));

   always #5 clk = ~clk;

   // Behavioural model of the fast instance
   int m_cnt, m_mode, m_duty, m_tmag, m_dead;
   bit m_dir, m_tdir;

   task automatic model_reset();
      m_cnt = 0; m_mode = M_IDLE; m_duty = 0; m_dir = 0;
      m_tdir = 0; m_tmag = 0; m_dead = 0;
   endtask

   task automatic model_edge(input bit e, input bit v, input logic [11:0] r);
      bit tick;
      int s, d;
      tick = (m_cnt == PF - 1);
      if (v) begin
         s = 32'(signed'(r));
         m_tdir = (s < 0);
         m_tmag = (s < 0) ? -s : s;
         if (m_tmag > 2047) m_tmag = 2047;
      end
      m_cnt = (m_cnt + 1) % PF;
      if (!e) begin
         m_mode = M_IDLE;
         m_duty = 0;
      end else if (tick) begin
         if (m_mode == M_IDLE) begin
            m_mode = M_RUN;
            m_dir  = m_tdir;
         end else if (m_mode == M_RUN) begin
            if (m_tdir == m_dir) begin
               d = m_tmag - m_duty;
               if (d > 32) d = 32;
               if (d < -32) d = -32;
               m_duty = m_duty + d;
            end else if (m_duty > 0) begin
               m_duty = (m_duty > 32) ? m_duty - 32 : 0;
            end else begin
               m_mode = M_DEAD;
               m_dead = 2;
            end
         end else begin
            if (m_dead == 1) begin
               m_mode = M_RUN;
               m_dir  = m_tdir;
            end else begin
               m_dead = m_dead - 1;
            end
         end
      end
   endtask

   function automatic logic [14:0] exp_vec();
      logic at;
      at = (m_mode == M_RUN) && (m_duty == m_tmag) && (m_dir == m_tdir);
      return {11'(m_duty), m_dir, (m_mode != M_RUN), at, (m_cnt == PF - 1)};
   endfunction

   function automatic logic [14:0] obs_vec();
      return {bf.duty, bf.dir, bf.coast, bf.at_spd, bf.prd_tick};
   endfunction

   function automatic logic [14:0] obs_slow();
      return {bs.duty, bs.dir, bs.coast, bs.at_spd, bs.prd_tick};
   endfunction

   // One clock: inputs seen by the edge feed the model, outputs settle 1 ns later
   task automatic clk_step();
      bit e, v;
      logic [11:0] r;
      e = bf.en; v = bf.req_vld; r = bf.spd_req;
      @(posedge clk); #1;
      if (!rst_n) model_reset();
      else model_edge(e, v, r);
   endtask

   task automatic sync_cnt(input int c);
      while (m_cnt != c) clk_step();
   endtask

   task automatic next_tick();
      do clk_step(); while (m_cnt != 0);
   endtask

   task automatic pulse_req(input logic [11:0] r);
      bf.spd_req = r; bf.req_vld = 1'b1;
      clk_step();
      bf.req_vld = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      bit found;
      rst_n = 1'b0; bf.en = 1'b0; bf.req_vld = 1'b0; bf.spd_req = '0;
      model_reset();
      repeat (3) clk_step();
      n_cmp++;
      if (obs_vec() !== RST_VEC) begin
         n_bad++; $display("FAIL reset_fast got %h want %h", obs_vec(), RST_VEC);
      end
      n_cmp++;
      if (obs_slow() !== RST_VEC) begin
         n_bad++; $display("FAIL reset_slow got %h want %h", obs_slow(), RST_VEC);
      end
      @(negedge clk) rst_n = 1'b1;
      n = 0; found = 0;
      while (n < 3000 && !found) begin
         clk_step(); n++;
         if (bs.prd_tick === 1'b1) found = 1;
         if (n < 200) begin
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
               n_bad++; $display("FAIL reset_run got %h want %h", obs_vec(), exp_vec());
            end
         end
      end
      n_cmp++;
      if (!found || n != PS - 1) begin
         n_bad++; $display("FAIL first_tick edges=%0d found=%0d want %0d", n, found, PS - 1);
      end
   endtask

   task automatic test_ramp_up();
      sync_cnt(5);
      bf.en = 1'b1;
      pulse_req(12'd1024);
      repeat (35 * PF) begin
         clk_step();
         if (m_cnt == 0) begin
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
               n_bad++; $display("FAIL ramp_up got %h want %h", obs_vec(), exp_vec());
            end
         end
      end
      n_cmp++;
      if ({bf.duty, bf.dir, bf.coast, bf.at_spd} !== {11'd1024, 1'b0, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL ramp_up_final got %0d/%b/%b/%b want 1024/0/0/1",
                           bf.duty, bf.dir, bf.coast, bf.at_spd);
      end
   endtask

   task automatic test_non_multiple();
      int exp_d[6] = '{0, 32, 64, 96, 100, 100};
      bit exp_a[6] = '{0, 0, 0, 0, 1, 1};
      sync_cnt(5);
      bf.en = 1'b0; clk_step();
      bf.en = 1'b1;
      pulse_req(12'd100);
      for (int k = 0; k < 6; k++) begin
         next_tick();
         n_cmp++;
         if (bf.duty !== 11'(exp_d[k]) || bf.at_spd !== exp_a[k] || obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL non_multiple tick%0d duty=%0d at=%b want %0d/%b",
                              k, bf.duty, bf.at_spd, exp_d[k], exp_a[k]);
         end
      end
   endtask

   task automatic test_reversal();
      int ed;
      logic edir, ec, ea;
      sync_cnt(5);
      pulse_req(12'd1024);
      repeat (31) next_tick();
      n_cmp++;
      if ({bf.duty, bf.at_spd} !== {11'd1024, 1'b1}) begin
         n_bad++; $display("FAIL reversal_pre got %0d/%b want 1024/1", bf.duty, bf.at_spd);
      end
      sync_cnt(5);
      pulse_req(12'hE00);
      for (int t = 1; t <= 52; t++) begin
         next_tick();
         if (t <= 32) begin ed = 1024 - 32 * t; edir = 0; ec = 0; end
         else if (t <= 34) begin ed = 0; edir = 0; ec = 1; end
         else if (t == 35) begin ed = 0; edir = 1; ec = 0; end
         else begin ed = 32 * (t - 35); if (ed > 512) ed = 512; edir = 1; ec = 0; end
         ea = (t >= 51);
         n_cmp++;
         if ({bf.duty, bf.dir, bf.coast, bf.at_spd} !== {11'(ed), edir, ec, ea}) begin
            n_bad++; $display("FAIL reversal t%0d got %0d/%b/%b/%b want %0d/%b/%b/%b",
                              t, bf.duty, bf.dir, bf.coast, bf.at_spd, ed, edir, ec, ea);
         end
      end
   endtask

   task automatic test_saturation();
      int ed;
      logic edir, ec;
      sync_cnt(5);
      bf.en = 1'b0; clk_step();
      bf.en = 1'b1;
      pulse_req(12'd0);
      repeat (2) next_tick();
      sync_cnt(5);
      pulse_req(12'h800);
      for (int t = 1; t <= 70; t++) begin
         next_tick();
         if (t <= 2) begin ed = 0; edir = 0; ec = 1; end
         else begin ed = 32 * (t - 3); if (ed > 2047) ed = 2047; edir = 1; ec = 0; end
         n_cmp++;
         if ({bf.duty, bf.dir, bf.coast} !== {11'(ed), edir, ec} || obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL saturation t%0d got %0d/%b/%b want %0d/%b/%b",
                              t, bf.duty, bf.dir, bf.coast, ed, edir, ec);
         end
      end
   endtask

   task automatic test_en_drop();
      sync_cnt(5);
      bf.en = 1'b0; clk_step();
      bf.en = 1'b1;
      pulse_req(12'd1024);
      while (m_duty != 320) clk_step();
      sync_cnt(10);
      bf.en = 1'b0;
      clk_step();
      n_cmp++;
      if ({bf.duty, bf.coast, bf.dir} !== {11'd0, 1'b1, 1'b0} || obs_vec() !== exp_vec()) begin
         n_bad++; $display("FAIL en_drop got %0d/%b want 0/1", bf.duty, bf.coast);
      end
      bf.en = 1'b1;
      next_tick();
      n_cmp++;
      if ({bf.duty, bf.coast} !== {11'd0, 1'b0}) begin
         n_bad++; $display("FAIL en_restart1 got %0d/%b want 0/0", bf.duty, bf.coast);
      end
      next_tick();
      n_cmp++;
      if ({bf.duty, bf.coast, bf.dir} !== {11'd32, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL en_restart2 got %0d/%b want 32/0", bf.duty, bf.coast);
      end
   endtask

   task automatic test_tick_coincide();
      sync_cnt(PF - 1);
      n_cmp++;
      if (bf.prd_tick !== 1'b1) begin
         n_bad++; $display("FAIL tick_strobe got %b want 1", bf.prd_tick);
      end
      pulse_req(12'd42);
      n_cmp++;
      if ({bf.duty, bf.at_spd} !== {11'd42, 1'b1}) begin
         n_bad++; $display("FAIL req_on_tick got %0d/%b want 42/1", bf.duty, bf.at_spd);
      end
      sync_cnt(PF - 1);
      bf.en = 1'b0;
      clk_step();
      n_cmp++;
      if ({bf.duty, bf.coast, bf.at_spd} !== {11'd0, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL en_on_tick got %0d/%b/%b want 0/1/0", bf.duty, bf.coast, bf.at_spd);
      end
      bf.en = 1'b1;
   endtask

   task automatic test_back_to_back();
      sync_cnt(5);
      bf.req_vld = 1'b1;
      bf.spd_req = 12'd200;  clk_step();
      bf.spd_req = 12'hFCE;  clk_step();
      bf.spd_req = 12'd300;  clk_step();
      bf.req_vld = 1'b0;
      next_tick();
      next_tick();
      n_cmp++;
      if ({bf.duty, bf.dir, bf.coast} !== {11'd32, 1'b0, 1'b0} || obs_vec() !== exp_vec()) begin
         n_bad++; $display("FAIL back_to_back got %0d/%b/%b want 32/0/0", bf.duty, bf.dir, bf.coast);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         bf.req_vld = ($urandom_range(0, 39) == 0);
         if (bf.req_vld)
            bf.spd_req = ($urandom_range(0, 1) == 1) ? 12'($urandom)
                                                     : 12'(int'($urandom_range(0, 400)) - 200);
         if (bf.en) bf.en = ($urandom_range(0, 399) != 0);
         else       bf.en = ($urandom_range(0, 19) == 0);
         clk_step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL random cyc%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      bf.req_vld = 1'b0;
      bf.en = 1'b1;
   endtask

   task automatic test_rst_mid_dead();
      int n;
      bit found;
      sync_cnt(5);
      bf.en = 1'b0; clk_step();
      bf.en = 1'b1;
      pulse_req(12'd0);
      repeat (2) next_tick();
      sync_cnt(5);
      pulse_req(12'hF9C);
      next_tick();
      sync_cnt(10);
      n_cmp++;
      if ({bf.coast, bf.duty} !== {1'b1, 11'd0} || obs_vec() !== exp_vec()) begin
         n_bad++; $display("FAIL dead_entry got coast=%b duty=%0d want 1/0", bf.coast, bf.duty);
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if (obs_vec() !== RST_VEC) begin
         n_bad++; $display("FAIL rst_async_fast got %h want %h", obs_vec(), RST_VEC);
      end
      n_cmp++;
      if (obs_slow() !== RST_VEC) begin
         n_bad++; $display("FAIL rst_async_slow got %h want %h", obs_slow(), RST_VEC);
      end
      @(negedge clk) rst_n = 1'b1;
      n = 0; found = 0;
      while (n < 3000 && !found) begin
         clk_step(); n++;
         if (bs.prd_tick === 1'b1) found = 1;
         if (n < 200) begin
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
               n_bad++; $display("FAIL rst_rerun got %h want %h", obs_vec(), exp_vec());
            end
         end
      end
      n_cmp++;
      if (!found || n != PS - 1) begin
         n_bad++; $display("FAIL rst_first_tick edges=%0d found=%0d want %0d", n, found, PS - 1);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_non_multiple();
      test_reversal();
      test_saturation();
      test_en_drop();
      test_tick_coincide();
      test_back_to_back();
      test_random();
      test_rst_mid_dead();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
